// File: rtl/ahb_junior_pkg.sv
// Shared types and constants for the AHB-Lite junior SRAM slave.
package ahb_junior_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned WAIT_CNT_W    = 4;
  localparam int unsigned WORD_OFF_BITS = 2;
  localparam logic [31:0] ERR_RDATA     = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LAST = 2'd2
  } state_e;

endpackage

// File: rtl/ahb_junior_sram.sv
// Word-wide SRAM: one synchronous write port, one registered read port,
// with same-edge write-to-read bypass.
module ahb_junior_sram
  import ahb_junior_pkg::*;
#(
  parameter int unsigned  AW      = 8,
  parameter logic [31:0]  RST_VAL = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] rdata_q;

  // Storage array, intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A read on the same edge as a write to that word must see the new data.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= RST_VAL;
    end else if (re_i) begin
      if (we_i && (waddr_i == raddr_i)) begin
        rdata_q <= wdata_i;
      end else begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_junior_sram_slave.sv
// AHB-Lite junior SRAM slave with programmable wait states.
// Optional out-of-range detection: define AHB_JUNIOR_SLV_RANGE_CHECK_EN.
module ahb_junior_sram_slave
  import ahb_junior_pkg::*;
#(
  parameter int unsigned MEM_AW      = 8,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] RDATA_IDLE  = 32'h0000_0000
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic              HWRITE,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADY
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CYCLES[WAIT_CNT_W-1:0];

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [MEM_AW-1:0]       addr_q, addr_d;
  logic                    write_q, write_d;
  logic                    oor_q, oor_d;
  logic                    hready_q;
  logic                    rd_err_q;

  logic                    accept_s;
  logic [MEM_AW-1:0]       haddr_idx_s;
  logic                    oor_s;
  logic                    rd_en_s;
  logic [MEM_AW-1:0]       rd_addr_s;
  logic                    rd_oor_s;
  logic                    wr_en_s;
  logic [DATA_W-1:0]       sram_rdata_s;
  logic                    unused_s;

  assign accept_s    = HSEL & hready_q;
  assign haddr_idx_s = HADDR[MEM_AW+WORD_OFF_BITS-1:WORD_OFF_BITS];

`ifdef AHB_JUNIOR_SLV_RANGE_CHECK_EN
  assign oor_s    = |HADDR[31:MEM_AW+WORD_OFF_BITS];
  assign unused_s = ^HADDR[WORD_OFF_BITS-1:0];
`else
  assign oor_s    = 1'b0;
  assign unused_s = ^{HADDR[31:MEM_AW+WORD_OFF_BITS], HADDR[WORD_OFF_BITS-1:0]};
`endif

  // Data-phase sequencing; the read strobe fires on the edge that enters LAST.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    oor_d     = oor_q;
    rd_en_s   = 1'b0;
    rd_addr_s = addr_q;
    rd_oor_s  = oor_q;
    wr_en_s   = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= {{(WAIT_CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = ST_LAST;
          rd_en_s = ~write_q;
        end else begin
          cnt_d = cnt_q - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_IDLE, ST_LAST: begin
        wr_en_s = (state_q == ST_LAST) && write_q && !oor_q;
        if (accept_s) begin
          addr_d  = haddr_idx_s;
          write_d = HWRITE;
          oor_d   = oor_s;
          if (WAIT_CYCLES == 32'd0) begin
            state_d   = ST_LAST;
            cnt_d     = {WAIT_CNT_W{1'b0}};
            rd_en_s   = ~HWRITE;
            rd_addr_s = haddr_idx_s;
            rd_oor_s  = oor_s;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; HREADY is registered from the next state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {WAIT_CNT_W{1'b0}};
      addr_q   <= {MEM_AW{1'b0}};
      write_q  <= 1'b0;
      oor_q    <= 1'b0;
      hready_q <= 1'b1;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      oor_q    <= oor_d;
      hready_q <= (state_d != ST_WAIT);
      if (rd_en_s) begin
        rd_err_q <= rd_oor_s;
      end
    end
  end

  ahb_junior_sram #(
    .AW      (MEM_AW),
    .RST_VAL (RDATA_IDLE)
  ) u_sram (
    .clk_i   (HCLK),
    .rst_n_i (HRESETn),
    .we_i    (wr_en_s),
    .waddr_i (addr_q),
    .wdata_i (HWDATA),
    .re_i    (rd_en_s & ~rd_oor_s),
    .raddr_i (rd_addr_s),
    .rdata_o (sram_rdata_s)
  );

  assign HRDATA = rd_err_q ? ERR_RDATA : sram_rdata_s;
  assign HREADY = hready_q;

endmodule

// File: tb/tb_ahb_junior_sram_slave.sv
// Directed bench: one slave with 2 wait states, one with zero wait states.
module tb_ahb_junior_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic        hwrite [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata [2];
  logic        hready [2];

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;
  int          low;

  always #5 clk = ~clk;

  ahb_junior_sram_slave #(.MEM_AW(8), .WAIT_CYCLES(0), .RDATA_IDLE(32'h0000_0000)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HWDATA(hwdata[0]), .HRDATA(hrdata[0]), .HREADY(hready[0])
  );

  ahb_junior_sram_slave #(.MEM_AW(8), .WAIT_CYCLES(2), .RDATA_IDLE(32'h0000_0000)) dut2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HWDATA(hwdata[1]), .HRDATA(hrdata[1]), .HREADY(hready[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated transfer, starting and ending 1 time unit after a rising edge.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rdat, output int nlow);
    hsel[d] = 1'b1; haddr[d] = a; hwrite[d] = wr;
    @(posedge clk); #1;
    hsel[d] = 1'b0; hwdata[d] = wd;
    nlow = 0;
    while (hready[d] !== 1'b1 && nlow < 20) begin
      nlow++;
      @(posedge clk); #1;
    end
    rdat = hrdata[d];
    @(posedge clk); #1;
    hwdata[d] = 32'h0;
  endtask

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      hsel[i] = 1'b0; haddr[i] = 32'h0; hwrite[i] = 1'b0; hwdata[i] = 32'h0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("reset_hready", {31'd0, hready[1]}, 32'd1);
    chk("reset_hrdata", hrdata[1], 32'h0000_0000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Two wait states: write then read 0x40
    xfer(1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, rd, low);
    chk("w2_write_low_cycles", low, 32'd2);
    xfer(1, 1'b0, 32'h0000_0040, 32'h0, rd, low);
    chk("w2_read_low_cycles", low, 32'd2);
    chk("w2_read_data", rd, 32'hCAFE_F00D);

    // Reset in the middle of a pending write
    xfer(1, 1'b1, 32'h0000_0010, 32'h1111_1111, rd, low);
    hsel[1] = 1'b1; haddr[1] = 32'h0000_0010; hwrite[1] = 1'b1;
    @(posedge clk); #1;
    hsel[1] = 1'b0; hwdata[1] = 32'h2222_2222;
    chk("mid_wait_hready", {31'd0, hready[1]}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hready", {31'd0, hready[1]}, 32'd1);
    chk("async_rst_hrdata", hrdata[1], 32'h0000_0000);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    hwdata[1] = 32'h0;
    xfer(1, 1'b0, 32'h0000_0010, 32'h0, rd, low);
    chk("aborted_write_old", rd, 32'h1111_1111);

    // Zero wait states: back-to-back write then read of 0x8 (bypass)
    hsel[0] = 1'b1; haddr[0] = 32'h0000_0008; hwrite[0] = 1'b1;
    @(posedge clk); #1;
    chk("b2b_write_hready", {31'd0, hready[0]}, 32'd1);
    hwrite[0] = 1'b0; hwdata[0] = 32'h1234_5678;
    @(posedge clk); #1;
    hsel[0] = 1'b0; hwdata[0] = 32'h0;
    chk("b2b_read_hready", {31'd0, hready[0]}, 32'd1);
    chk("b2b_bypass_data", hrdata[0], 32'h1234_5678);
    @(posedge clk); #1;

    // Read-then-write the same word
    xfer(0, 1'b1, 32'h0000_0004, 32'hAAAA_AAAA, rd, low);
    hsel[0] = 1'b1; haddr[0] = 32'h0000_0004; hwrite[0] = 1'b0;
    @(posedge clk); #1;
    chk("rtw_read_old", hrdata[0], 32'hAAAA_AAAA);
    hwrite[0] = 1'b1;
    @(posedge clk); #1;
    hsel[0] = 1'b0; hwdata[0] = 32'h5555_5555;
    chk("rtw_hrdata_hold", hrdata[0], 32'hAAAA_AAAA);
    @(posedge clk); #1;
    hwdata[0] = 32'h0;
    xfer(0, 1'b0, 32'h0000_0004, 32'h0, rd, low);
    chk("rtw_read_new", rd, 32'h5555_5555);

`ifdef AHB_JUNIOR_SLV_RANGE_CHECK_EN
    xfer(1, 1'b1, 32'h0000_0000, 32'h0000_0012, rd, low);
    xfer(1, 1'b1, 32'h0000_0400, 32'h0000_0077, rd, low);
    chk("oor_write_low_cycles", low, 32'd2);
    xfer(1, 1'b0, 32'h0000_0400, 32'h0, rd, low);
    chk("oor_read_low_cycles", low, 32'd2);
    chk("oor_read_data", rd, 32'hDEAD_BEEF);
    xfer(1, 1'b0, 32'h0000_0000, 32'h0, rd, low);
    chk("oor_word0_unchanged", rd, 32'h0000_0012);
`else
    xfer(0, 1'b1, 32'h0000_0404, 32'h0000_0001, rd, low);
    xfer(0, 1'b0, 32'h0000_0004, 32'h0, rd, low);
    chk("alias_read", rd, 32'h0000_0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_junior_sram_slave.md
Name: ahb_junior_sram_slave

Overview:
- Single AHB-Lite "Junior" bus slave: 32-bit word-addressed SRAM that sits directly downstream of the junior bus master.
- Consumes HADDR/HWRITE/HWDATA and returns HRDATA/HREADY.
- Inserts a programmable number of wait states per transfer so the bench can exercise master stall handling.
- Only slave on the bus; it alone drives HREADY.

Parameters:
- MEM_AW, 8, word-address bits; depth = 2**MEM_AW words (default 256 x 32).
- WAIT_CYCLES, 1, wait states (HREADY low cycles) per data phase, range 0..15.
- RDATA_IDLE, 32'h0000_0000, HRDATA value after reset.

Ports:
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select; 1 = current address phase targets this slave.
- HADDR  in  32  byte address; bits [MEM_AW+1:2] index memory, [1:0] ignored.
- HWRITE  in  1  1 = write, 0 = read (address-phase signal).
- HWDATA  in  32  write data (data-phase signal).
- HRDATA  out  32  read data, valid when HREADY=1 in a read data phase.
- HREADY  out  1  1 = current data phase completes this cycle.

Behaviour:
- Reset (HRESETn=0, async): state=IDLE, HREADY=1, HRDATA=RDATA_IDLE, wait counter=0, pending flags cleared. Memory contents not reset. Reset mid-transfer aborts it; a pending write is not committed.
- Address phase accepted on a rising edge with HSEL=1 and HREADY=1.
  - Captures addr_q=HADDR[MEM_AW+1:2] and write_q=HWRITE.
  - Enters data phase.
  - HSEL=0 at an accepting edge returns the slave to IDLE.
- States:
  - IDLE: no data phase; HREADY=1.
  - WAIT: HREADY=0; counter decrements; at 1 -> LAST.
  - LAST: HREADY=1; data phase completes.
- Transitions:
  - Accept with WAIT_CYCLES>0 -> WAIT, counter=WAIT_CYCLES.
  - Accept with WAIT_CYCLES=0 -> LAST.
  - LAST with a new accept -> WAIT or LAST (back-to-back, pipelined).
  - LAST without accept -> IDLE.
- While HREADY=0, HADDR/HWRITE/HSEL are ignored; the master must hold them.
- Write: mem[addr_q] <= HWDATA on the edge ending LAST. HWDATA is sampled only at that edge.
- Read: memory read is registered at the edge entering LAST. HRDATA is valid throughout LAST and holds until the next read completes. Non-read phases do not disturb HRDATA.
- Latency: with WAIT_CYCLES=N, read data appears N+1 cycles after address acceptance; sustained throughput is one transfer per N+1 cycles.
- Write-then-read same word, back-to-back: when the read is registered at the same edge that commits a write to the same index, HRDATA takes HWDATA (bypass). Stale data is a failure.
- Read-then-write same word: the read returns the old value.
- Address wrap: with the feature off, HADDR bits above MEM_AW+1 are ignored, so addresses alias modulo 4*2**MEM_AW bytes.

Optional Feature:
- Macro AHB_JUNIOR_SLV_RANGE_CHECK_EN.
- When defined, an address phase with any HADDR[31:MEM_AW+2] nonzero is out of range:
  - the write is discarded and memory is unchanged;
  - the read returns 32'hDEAD_BEEF;
  - wait-state timing is unchanged.
- When undefined, addresses alias as described under Behaviour, and no comparator logic is synthesised.

Decomposition:
- Package ahb_junior_pkg:
  - state enum (IDLE, WAIT, LAST);
  - DATA_W=32;
  - WAIT_CNT_W=4;
  - ERR_RDATA=32'hDEAD_BEEF;
  - helper constant for word-offset bits (2).
- Sub-module ahb_junior_sram: one synchronous write port, one registered read port, with write-to-read bypass inside. The top holds the FSM, wait counter, address/control capture and range check.

Test Plan:
- Reset: HRESETn low mid-WAIT, pending write to 0x10 -> HREADY=1, HRDATA=0 immediately (async); a later read of 0x10 shows the old value.
- WAIT_CYCLES=2: write 0x0000_0040 <- 0xCAFE_F00D, then read 0x40 -> HREADY low exactly 2 cycles per phase; HRDATA=0xCAFE_F00D in the read's LAST cycle.
- WAIT_CYCLES=0: back-to-back write 0x8 <- 0x1234_5678 then read 0x8 -> one transfer per cycle; read returns 0x1234_5678 via bypass.
- Read 0x4 (holds 0xAAAA_AAAA) then write 0x4 <- 0x5555_5555 back-to-back -> read returns 0xAAAA_AAAA; a subsequent read returns 0x5555_5555.
- Alias, feature off, MEM_AW=8: write 0x404 <- 0x1 -> read 0x004 returns 0x1.
- Feature on: write 0x400 <- 0x77 is discarded; read 0x400 -> 0xDEAD_BEEF; read 0x000 is unchanged.
